lsu_controller: RTL and testbench
=================================

Name: lsu_controller

Overview:
- Load/store sequencer between the execute stage and the word-addressed data memory (sync write, combinational read).
- Converts RISC-V byte/halfword/word loads and stores into word accesses.
- Loads: byte-lane extraction with sign/zero extension. Sub-word stores: read-modify-write sequence.
- Flags misaligned accesses and illegal funct3 values instead of touching memory.

Parameters:
- ADDR_WIDTH, 32, width of req_addr and mem_a.
- DATA_WIDTH, 32, data width; fixed at 32, other values unsupported.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_funct3  input  3  RISC-V funct3 (LB/SB 000, LH/SH 001, LW/SW 010, LBU 100, LHU 101).
- req_addr  input  ADDR_WIDTH  byte address.
- req_wdata  input  32  store data, right-aligned.
- rsp_valid  output  1  one-cycle response pulse.
- rsp_rdata  output  32  load result, extended; 0 for stores and errors.
- rsp_err  output  1  misaligned or illegal funct3; valid with rsp_valid.
- mem_we  output  1  data memory write enable.
- mem_a  output  ADDR_WIDTH  word index = {2'b00, addr_q[ADDR_WIDTH-1:2]}.
- mem_wd  output  32  data memory write data.
- mem_rd  input  32  data memory combinational read data.

Behaviour:
- States: IDLE, LOAD, RMW_RD, WRITE, RESP.
- Reset (asynchronous): state = IDLE; rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, mem_we = 0; address, data and funct3 registers = 0.
- mem_we is decoded from state (1 only in WRITE), so assertion of rst forces it low immediately.
- A reset during RMW_RD or WRITE aborts the sequence. No write occurs on any edge at which rst is high.
- req_ready = 1 only in IDLE.
- Accept occurs on a clk edge with req_valid && req_ready. Latch addr, funct3, wdata and we into addr_q, f3_q, wd_q, we_q.
- Error check at accept:
  - Halfword access with addr[0] != 0 is misaligned.
  - Word access with addr[1:0] != 0 is misaligned.
  - Load funct3 in {011, 110, 111} is illegal.
  - Store funct3 other than 000/001/010 is illegal.
  - On error go straight to RESP with err_q = 1. No memory write.
- Transitions on a legal accept:
  - Load: IDLE -> LOAD.
  - SW: IDLE -> WRITE.
  - SB/SH: IDLE -> RMW_RD.
- LOAD: sample mem_rd at the end of the cycle.
  - Lane = addr_q[1:0] for bytes, addr_q[1] for halfwords.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - Result goes to rsp_rdata; next state RESP.
- RMW_RD: capture mem_rd into merge register; next state WRITE.
- WRITE: mem_we = 1.
  - mem_wd = wd_q for SW.
  - For SB/SH, mem_wd = merge register with the addressed byte/halfword lane replaced by wd_q[7:0] / wd_q[15:0].
  - Next state RESP.
- RESP: rsp_valid = 1 for exactly one cycle; rsp_err = err_q; rsp_rdata = 0 for stores and errors. Next state IDLE. No back-pressure on the response.
- Latency, accept edge = cycle 0: rsp_valid is high in cycle 2 for loads and SW, cycle 3 for SB/SH, cycle 1 for errors. Next accept is possible one cycle after RESP.
- mem_a holds the latched word index in every non-IDLE state and is stable across RMW_RD -> WRITE. In IDLE it drives addr_q (don't-care to memory).
- req_valid with req_ready = 0 is ignored; the requester must hold the request.

Test Plan:
- Reset/idle: assert rst mid-cycle -> rsp_valid = 0, mem_we = 0 immediately; req_ready = 1 after release.
- SW then LW: SW addr 0x10, data 0xDEADBEEF -> mem_we pulse at mem_a = 4 in cycle 1, rsp in cycle 2. LW 0x10 -> rsp_rdata = 0xDEADBEEF, err = 0, rsp in cycle 2.
- SB RMW: word 4 = 0x11223344; SB addr 0x12, data 0xAA -> read in cycle 1, write 0x11AA3344 in cycle 2, rsp in cycle 3. LBU 0x12 -> 0x000000AA; LB 0x12 -> 0xFFFFFFAA.
- SH/LH: SH addr 0x16, data 0x8001 over word 5 = 0 -> memory 0x80010000. LH 0x16 -> 0xFFFF8001; LHU -> 0x00008001.
- Errors: LW 0x11, SH 0x13, load funct3 011 -> rsp_err = 1 in cycle 1, rsp_rdata = 0, mem_we never asserted, memory unchanged.
- Reset mid-RMW: SB issued, rst asserted during WRITE -> no write, word unchanged, no rsp_valid, state IDLE.

Source files
------------

// File: rtl/lsu_controller.sv
`default_nettype none
// ============================================================================
// Module   : lsu_controller
// Purpose  : Load/store sequencer between the execute stage and a
//            word-addressed data memory (sync write, combinational read).
//            Turns RISC-V byte/halfword/word loads and stores into word
//            accesses: loads extract and extend the addressed lane, sub-word
//            stores run a read-modify-write. Misaligned accesses and illegal
//            funct3 values are reported with rsp_err and never touch memory.
// Ports    : clk, rst          - clock, asynchronous active-high reset
//            req_valid/ready   - request handshake (ready only in IDLE)
//            req_we/funct3     - store flag and RISC-V funct3
//            req_addr/wdata    - byte address, right-aligned store data
//            rsp_valid/rdata/err - one-cycle response pulse
//            mem_we/a/wd/rd    - data memory port (word index on mem_a)
// Revision : 1.0 - initial release
// ============================================================================
module lsu_controller #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic [DATA_WIDTH-1:0] mem_wd,
  input  logic [DATA_WIDTH-1:0] mem_rd
);

  localparam logic [2:0] c_F3_B  = 3'b000;
  localparam logic [2:0] c_F3_H  = 3'b001;
  localparam logic [2:0] c_F3_W  = 3'b010;
  localparam logic [2:0] c_F3_BU = 3'b100;
  localparam logic [2:0] c_F3_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RMW_RD = 3'd2,
    S_WRITE  = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [ADDR_WIDTH-1:0]   r_addr_q;
  logic [2:0]              r_f3_q;
  logic [DATA_WIDTH-1:0]   r_wd_q;
  logic                    r_we_q;
  logic                    r_err_q;
  logic [DATA_WIDTH-1:0]   r_merge_q;
  logic [DATA_WIDTH-1:0]   r_rdata_q;

  logic                    w_accept;
  logic                    w_req_err;
  logic [7:0]              w_byte;
  logic [15:0]             w_half;
  logic [DATA_WIDTH-1:0]   w_load_data;
  logic [DATA_WIDTH-1:0]   w_merged;

  assign w_accept = req_valid && (r_state == S_IDLE);

  // Request legality, evaluated on the raw request so the error path can
  // skip every memory state.
  always_comb begin
    w_req_err = 1'b0;
    if (req_we) begin
      case (req_funct3)
        c_F3_B:  w_req_err = 1'b0;
        c_F3_H:  w_req_err = req_addr[0];
        c_F3_W:  w_req_err = |req_addr[1:0];
        default: w_req_err = 1'b1;
      endcase
    end else begin
      case (req_funct3)
        c_F3_B, c_F3_BU: w_req_err = 1'b0;
        c_F3_H, c_F3_HU: w_req_err = req_addr[0];
        c_F3_W:          w_req_err = |req_addr[1:0];
        default:         w_req_err = 1'b1;
      endcase
    end
  end

  // Load lane extraction and extension.
  always_comb begin
    case (r_addr_q[1:0])
      2'd0:    w_byte = mem_rd[7:0];
      2'd1:    w_byte = mem_rd[15:8];
      2'd2:    w_byte = mem_rd[23:16];
      default: w_byte = mem_rd[31:24];
    endcase
    w_half = r_addr_q[1] ? mem_rd[31:16] : mem_rd[15:0];
    case (r_f3_q)
      c_F3_B:  w_load_data = {{24{w_byte[7]}}, w_byte};
      c_F3_H:  w_load_data = {{16{w_half[15]}}, w_half};
      c_F3_BU: w_load_data = {24'd0, w_byte};
      c_F3_HU: w_load_data = {16'd0, w_half};
      default: w_load_data = mem_rd;
    endcase
  end

  // Sub-word store merge: the word read in RMW_RD with one lane replaced.
  always_comb begin
    w_merged = r_merge_q;
    if (r_f3_q == c_F3_B) begin
      case (r_addr_q[1:0])
        2'd0:    w_merged[7:0]   = r_wd_q[7:0];
        2'd1:    w_merged[15:8]  = r_wd_q[7:0];
        2'd2:    w_merged[23:16] = r_wd_q[7:0];
        default: w_merged[31:24] = r_wd_q[7:0];
      endcase
    end else if (r_addr_q[1]) begin
      w_merged[31:16] = r_wd_q[15:0];
    end else begin
      w_merged[15:0] = r_wd_q[15:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_addr_q  <= '0;
      r_f3_q    <= '0;
      r_wd_q    <= '0;
      r_we_q    <= 1'b0;
      r_err_q   <= 1'b0;
      r_merge_q <= '0;
      r_rdata_q <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_addr_q  <= req_addr;
        r_f3_q    <= req_funct3;
        r_wd_q    <= req_wdata;
        r_we_q    <= req_we;
        r_err_q   <= w_req_err;
        r_rdata_q <= '0;
      end
      if (r_state == S_LOAD) begin
        r_rdata_q <= w_load_data;
      end
      if (r_state == S_RMW_RD) begin
        r_merge_q <= mem_rd;
      end
    end
  end

  // Next state and state-decoded outputs. mem_we depends only on r_state so
  // an asynchronous reset drops it immediately.
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    rsp_err     = 1'b0;
    rsp_rdata   = '0;
    mem_we      = 1'b0;
    mem_wd      = (r_f3_q == c_F3_W) ? r_wd_q : w_merged;
    mem_a       = {2'b00, r_addr_q[ADDR_WIDTH-1:2]};
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (w_req_err)                 w_state_nxt = S_RESP;
          else if (!req_we)              w_state_nxt = S_LOAD;
          else if (req_funct3 == c_F3_W) w_state_nxt = S_WRITE;
          else                           w_state_nxt = S_RMW_RD;
        end
      end
      S_LOAD:   w_state_nxt = S_RESP;
      S_RMW_RD: w_state_nxt = S_WRITE;
      S_WRITE: begin
        mem_we      = 1'b1;
        w_state_nxt = S_RESP;
      end
      S_RESP: begin
        rsp_valid   = 1'b1;
        rsp_err     = r_err_q;
        rsp_rdata   = (r_we_q || r_err_q) ? '0 : r_rdata_q;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_lsu_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_controller
// Purpose  : Directed self-checking bench for lsu_controller with a 64-word
//            behavioural data memory (sync write, combinational read).
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_controller;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  logic [31:0] mem [0:63];
  logic        pre_en;
  logic [5:0]  pre_idx;
  logic [31:0] pre_data;

  int checks = 0;
  int errors = 0;

  // Observations filled in by run_txn
  int          obs_lat;
  int          obs_wcount;
  int          obs_wcycle;
  logic        obs_ready;
  logic        obs_err;
  logic [31:0] obs_rdata;
  logic [31:0] obs_wa;
  logic [31:0] obs_wd;
  logic        obs_a_stable;
  logic        obs_rsp_ready;
  logic        obs_after_valid;
  logic        obs_after_ready;

  lsu_controller #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_we     (mem_we),
    .mem_a      (mem_a),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rd = mem[mem_a[5:0]];

  always @(posedge clk) begin
    if (mem_we)      mem[mem_a[5:0]] <= mem_wd;
    else if (pre_en) mem[pre_idx]    <= pre_data;
  end

  task automatic preload(input logic [5:0] idx, input logic [31:0] data);
    @(negedge clk);
    pre_en = 1'b1; pre_idx = idx; pre_data = data;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  // Drives one request and records what the DUT does until the response
  // plus one cycle. Cycle numbers count from the accept edge.
  task automatic run_txn(input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
    int          c;
    logic [31:0] a0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    obs_ready = req_ready;
    @(posedge clk); #1;
    req_valid = 1'b0;
    obs_lat = -1; obs_wcount = 0; obs_wcycle = -1; obs_err = 1'b0;
    obs_rdata = 32'h0; obs_wa = 32'h0; obs_wd = 32'h0;
    obs_a_stable = 1'b1; obs_rsp_ready = 1'b0;
    a0 = mem_a;
    c = 1;
    while (c <= 8 && obs_lat < 0) begin
      if (mem_a !== a0) obs_a_stable = 1'b0;
      if (mem_we) begin
        obs_wcount++; obs_wcycle = c; obs_wa = mem_a; obs_wd = mem_wd;
      end
      if (rsp_valid) begin
        obs_lat = c; obs_err = rsp_err; obs_rdata = rsp_rdata; obs_rsp_ready = req_ready;
      end
      @(posedge clk); #1;
      c++;
    end
    obs_after_valid = rsp_valid;
    obs_after_ready = req_ready;
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
    req_addr = 32'h0; req_wdata = 32'h0; pre_en = 1'b0; pre_idx = 6'd0; pre_data = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1; #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
    checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rsp_rdata); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", rsp_err); end
    checks++; if (mem_a !== 32'h0) begin errors++; $display("FAIL reset_mem_a: got %h want 0", mem_a); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_sw_lw;
    run_txn(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL sw_ready: got %b want 1", obs_ready); end
    checks++; if (obs_lat !== 2) begin errors++; $display("FAIL sw_latency: got %0d want 2", obs_lat); end
    checks++; if (obs_wcount !== 1 || obs_wcycle !== 1) begin errors++; $display("FAIL sw_write_cycle: got count %0d cycle %0d want 1/1", obs_wcount, obs_wcycle); end
    checks++; if (obs_wa !== 32'd4) begin errors++; $display("FAIL sw_mem_a: got %h want 4", obs_wa); end
    checks++; if (obs_wd !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_mem_wd: got %h want deadbeef", obs_wd); end
    checks++; if (obs_err !== 1'b0 || obs_rdata !== 32'h0) begin errors++; $display("FAIL sw_rsp: got err %b rdata %h want 0/0", obs_err, obs_rdata); end
    checks++; if (obs_rsp_ready !== 1'b0) begin errors++; $display("FAIL sw_ready_in_resp: got %b want 0", obs_rsp_ready); end
    checks++; if (obs_after_valid !== 1'b0 || obs_after_ready !== 1'b1) begin errors++; $display("FAIL sw_after: got valid %b ready %b want 0/1", obs_after_valid, obs_after_ready); end
    checks++; if (mem[4] !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_mem_word: got %h want deadbeef", mem[4]); end
    run_txn(1'b0, 3'b010, 32'h10, 32'h0);
    checks++; if (obs_lat !== 2) begin errors++; $display("FAIL lw_latency: got %0d want 2", obs_lat); end
    checks++; if (obs_rdata !== 32'hDEADBEEF || obs_err !== 1'b0) begin errors++; $display("FAIL lw_rdata: got %h err %b want deadbeef/0", obs_rdata, obs_err); end
    checks++; if (obs_wcount !== 0) begin errors++; $display("FAIL lw_no_write: got %0d want 0", obs_wcount); end
  endtask

  task automatic test_sb_rmw;
    preload(6'd4, 32'h11223344);
    run_txn(1'b1, 3'b000, 32'h12, 32'h000000AA);
    checks++; if (obs_lat !== 3) begin errors++; $display("FAIL sb_latency: got %0d want 3", obs_lat); end
    checks++; if (obs_wcount !== 1 || obs_wcycle !== 2) begin errors++; $display("FAIL sb_write_cycle: got count %0d cycle %0d want 1/2", obs_wcount, obs_wcycle); end
    checks++; if (obs_wd !== 32'h11AA3344 || obs_wa !== 32'd4) begin errors++; $display("FAIL sb_merge: got %h @%h want 11aa3344 @4", obs_wd, obs_wa); end
    checks++; if (obs_a_stable !== 1'b1) begin errors++; $display("FAIL sb_mem_a_stable: got %b want 1", obs_a_stable); end
    run_txn(1'b0, 3'b100, 32'h12, 32'h0);
    checks++; if (obs_rdata !== 32'h000000AA) begin errors++; $display("FAIL lbu_12: got %h want 000000aa", obs_rdata); end
    run_txn(1'b0, 3'b000, 32'h12, 32'h0);
    checks++; if (obs_rdata !== 32'hFFFFFFAA) begin errors++; $display("FAIL lb_12: got %h want ffffffaa", obs_rdata); end
    run_txn(1'b0, 3'b000, 32'h13, 32'h0);
    checks++; if (obs_rdata !== 32'h00000011) begin errors++; $display("FAIL lb_13: got %h want 00000011", obs_rdata); end
    run_txn(1'b0, 3'b100, 32'h10, 32'h0);
    checks++; if (obs_rdata !== 32'h00000044) begin errors++; $display("FAIL lbu_10: got %h want 00000044", obs_rdata); end
  endtask

  task automatic test_sh_lh;
    preload(6'd5, 32'h0);
    run_txn(1'b1, 3'b001, 32'h16, 32'h00008001);
    checks++; if (obs_lat !== 3 || obs_wd !== 32'h80010000) begin errors++; $display("FAIL sh_16: got lat %0d wd %h want 3/80010000", obs_lat, obs_wd); end
    run_txn(1'b0, 3'b001, 32'h16, 32'h0);
    checks++; if (obs_rdata !== 32'hFFFF8001) begin errors++; $display("FAIL lh_16: got %h want ffff8001", obs_rdata); end
    run_txn(1'b0, 3'b101, 32'h16, 32'h0);
    checks++; if (obs_rdata !== 32'h00008001) begin errors++; $display("FAIL lhu_16: got %h want 00008001", obs_rdata); end
    run_txn(1'b0, 3'b001, 32'h14, 32'h0);
    checks++; if (obs_rdata !== 32'h0) begin errors++; $display("FAIL lh_14: got %h want 0", obs_rdata); end
    run_txn(1'b1, 3'b001, 32'h14, 32'hFFFF1234);
    checks++; if (obs_wd !== 32'h80011234) begin errors++; $display("FAIL sh_14: got %h want 80011234", obs_wd); end
    run_txn(1'b0, 3'b010, 32'h14, 32'h0);
    checks++; if (obs_rdata !== 32'h80011234) begin errors++; $display("FAIL lw_14: got %h want 80011234", obs_rdata); end
  endtask

  task automatic test_errors;
    run_txn(1'b0, 3'b010, 32'h11, 32'h0);
    checks++; if (obs_lat !== 1 || obs_err !== 1'b1 || obs_rdata !== 32'h0) begin errors++; $display("FAIL err_lw_11: got lat %0d err %b rdata %h want 1/1/0", obs_lat, obs_err, obs_rdata); end
    run_txn(1'b1, 3'b001, 32'h13, 32'h0000BEEF);
    checks++; if (obs_lat !== 1 || obs_err !== 1'b1 || obs_wcount !== 0) begin errors++; $display("FAIL err_sh_13: got lat %0d err %b writes %0d want 1/1/0", obs_lat, obs_err, obs_wcount); end
    checks++; if (mem[4] !== 32'h11AA3344) begin errors++; $display("FAIL err_mem_word: got %h want 11aa3344", mem[4]); end
    run_txn(1'b0, 3'b011, 32'h10, 32'h0);
    checks++; if (obs_lat !== 1 || obs_err !== 1'b1 || obs_rdata !== 32'h0) begin errors++; $display("FAIL err_ld_f3_011: got lat %0d err %b rdata %h want 1/1/0", obs_lat, obs_err, obs_rdata); end
    run_txn(1'b1, 3'b100, 32'h10, 32'h12345678);
    checks++; if (obs_lat !== 1 || obs_err !== 1'b1 || obs_wcount !== 0) begin errors++; $display("FAIL err_st_f3_100: got lat %0d err %b writes %0d want 1/1/0", obs_lat, obs_err, obs_wcount); end
    run_txn(1'b0, 3'b101, 32'h15, 32'h0);
    checks++; if (obs_lat !== 1 || obs_err !== 1'b1) begin errors++; $display("FAIL err_lhu_15: got lat %0d err %b want 1/1", obs_lat, obs_err); end
    run_txn(1'b1, 3'b010, 32'h12, 32'h0);
    checks++; if (obs_lat !== 1 || obs_err !== 1'b1 || obs_wcount !== 0) begin errors++; $display("FAIL err_sw_12: got lat %0d err %b writes %0d want 1/1/0", obs_lat, obs_err, obs_wcount); end
    checks++; if (mem[4] !== 32'h11AA3344) begin errors++; $display("FAIL err_mem_final: got %h want 11aa3344", mem[4]); end
  endtask

  task automatic test_reset_mid_rmw;
    int vseen;
    int wseen;
    preload(6'd6, 32'hCAFEF00D);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h19; req_wdata = 32'h55;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (mem_we !== 1'b1 || mem_a !== 32'd6) begin errors++; $display("FAIL rmw_in_write: got we %b a %h want 1/6", mem_we, mem_a); end
    #2 rst = 1'b1; #1;
    checks++; if (mem_we !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rmw_rst_immediate: got we %b valid %b want 0/0", mem_we, rsp_valid); end
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    vseen = 0; wseen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (rsp_valid) vseen++;
      if (mem_we) wseen++;
    end
    checks++; if (vseen !== 0 || wseen !== 0) begin errors++; $display("FAIL rmw_abort: got rsp %0d writes %0d want 0/0", vseen, wseen); end
    checks++; if (mem[6] !== 32'hCAFEF00D) begin errors++; $display("FAIL rmw_word_kept: got %h want cafef00d", mem[6]); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rmw_idle: got ready %b want 1", req_ready); end
  endtask

  initial begin
    test_reset();
    test_sw_lw();
    test_sb_rmw();
    test_sh_lh();
    test_errors();
    test_reset_mid_rmw();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
